// File: rtl/synth_pkg.sv
// Shared widths and FSM state encoding for the partial scheduler.
// Imported by the scheduler top and its config register file.
package synth_pkg;

  localparam int RATIO_W    = 16;
  localparam int RATIO_FRAC = 8;
  localparam int AMP_W      = 8;
  localparam int PHASE_W    = 32;
  localparam int SAMPLE_W   = 16;
  localparam int ACC_W      = 20;
  localparam int STEP_W     = 26;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ISSUE,
    WAIT,
    ACC,
    DONE
  } sched_state_t;

endpackage

// File: rtl/partial_cfg_regfile.sv
// Per-slot ratio/amp/phase storage: cfg write port, phase write port,
// and a combinational read at the current slot.
module partial_cfg_regfile
  import synth_pkg::*;
#(
  parameter int NUM_PARTIALS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_idx,
  input  logic [RATIO_W-1:0] cfg_ratio,
  input  logic [AMP_W-1:0]   cfg_amp,
  input  logic               phase_we,
  input  logic [3:0]         slot,
  input  logic [PHASE_W-1:0] phase_data,
  output logic [RATIO_W-1:0] ratio,
  output logic [AMP_W-1:0]   amp,
  output logic [PHASE_W-1:0] phase
);

  localparam logic [4:0] NP = 5'(NUM_PARTIALS);

  logic [RATIO_W-1:0] ratio_q [NUM_PARTIALS];
  logic [AMP_W-1:0]   amp_q   [NUM_PARTIALS];
  logic [PHASE_W-1:0] phase_q [NUM_PARTIALS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PARTIALS; i++) begin
        ratio_q[i] <= '0;
        amp_q[i]   <= '0;
        phase_q[i] <= '0;
      end
    end else begin
      if (cfg_we && ({1'b0, cfg_idx} < NP)) begin
        ratio_q[cfg_idx] <= cfg_ratio;
        amp_q[cfg_idx]   <= cfg_amp;
      end
      if (phase_we)
        phase_q[slot] <= phase_data;
    end
  end

  assign ratio = ratio_q[slot];
  assign amp   = amp_q[slot];
  assign phase = phase_q[slot];

endmodule

// File: rtl/partial_scheduler.sv
// Time-multiplexes one shared sine datapath across nonharmonic partials,
// summing amplitude-scaled responses into one sample per audio tick.
module partial_scheduler
  import synth_pkg::*;
#(
  parameter int         NUM_PARTIALS = 16,
  parameter logic [11:0] TICK_COUNT  = 12'd0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [11:0]                sample_cycle_count,
  input  logic [17:0]                base_freq_in,
  input  logic                       cfg_we,
  input  logic [3:0]                 cfg_idx,
  input  logic [RATIO_W-1:0]         cfg_ratio,
  input  logic [AMP_W-1:0]           cfg_amp,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [PHASE_W-1:0]         req_phase,
  input  logic                       resp_valid,
  input  logic signed [SAMPLE_W-1:0] resp_sample,
  output logic [ACC_W-1:0]           sample_out,
  output logic                       sample_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam logic [3:0] LAST = 4'(NUM_PARTIALS - 1);

  sched_state_t state, state_nx;

  logic [3:0]                 slot;
  logic                       tick;
  logic [RATIO_W-1:0]         rd_ratio;
  logic [AMP_W-1:0]           rd_amp;
  logic [PHASE_W-1:0]         rd_phase;
  logic                       enabled;
  logic                       phase_we;
  logic [33:0]                prod;
  logic [STEP_W-1:0]          step;
  logic [PHASE_W-1:0]         phase_nx;
  logic [PHASE_W-1:0]         cur_phase;
  logic [AMP_W-1:0]           cur_amp;
  logic signed [SAMPLE_W-1:0] resp_q;
  logic signed [SAMPLE_W+AMP_W:0] mult;
  logic signed [SAMPLE_W-1:0] term;
  logic [ACC_W-1:0]           acc;
  logic                       unused_bits;

  assign tick     = (sample_cycle_count == TICK_COUNT);
  assign enabled  = (rd_ratio != '0);
  assign phase_we = (state == SCAN) && enabled;

  assign prod     = 34'(base_freq_in) * 34'(rd_ratio);
  assign step     = prod[RATIO_FRAC +: STEP_W];
  assign phase_nx = rd_phase + {{(PHASE_W-STEP_W){1'b0}}, step};

  // amp is unsigned; the zero MSB keeps 255 from reading as -1
  assign mult = resp_q * $signed({1'b0, cur_amp});
  assign term = mult[AMP_W +: SAMPLE_W];

  assign unused_bits = ^{mult[SAMPLE_W+AMP_W], mult[AMP_W-1:0],
                         prod[RATIO_FRAC-1:0]};

  partial_cfg_regfile #(
    .NUM_PARTIALS(NUM_PARTIALS)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_ratio (cfg_ratio),
    .cfg_amp   (cfg_amp),
    .phase_we  (phase_we),
    .slot      (slot),
    .phase_data(phase_nx),
    .ratio     (rd_ratio),
    .amp       (rd_amp),
    .phase     (rd_phase)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (tick) state_nx = SCAN;
      SCAN: begin
        if (enabled)           state_nx = ISSUE;
        else if (slot == LAST) state_nx = DONE;
      end
      ISSUE: if (req_ready)  state_nx = WAIT;
      WAIT:  if (resp_valid) state_nx = ACC;
      ACC:   state_nx = (slot == LAST) ? DONE : SCAN;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_valid = (state == ISSUE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot         <= '0;
      cur_phase    <= '0;
      cur_amp      <= '0;
      resp_q       <= '0;
      acc          <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (tick && (state != IDLE))
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (tick) begin
            acc  <= '0;
            slot <= '0;
          end
        end
        SCAN: begin
          if (enabled) begin
            cur_phase <= phase_nx;
            cur_amp   <= rd_amp;
          end else if (slot != LAST) begin
            slot <= slot + 4'd1;
          end
        end
        WAIT: if (resp_valid) resp_q <= resp_sample;
        ACC: begin
          acc <= acc + {{(ACC_W-SAMPLE_W){term[SAMPLE_W-1]}}, term};
          if (slot != LAST) slot <= slot + 4'd1;
        end
        DONE: begin
          sample_out   <= acc;
          sample_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_phase = cur_phase;

endmodule

// File: tb/tb_partial_scheduler.sv
// Directed bench for partial_scheduler with a one-cycle echo datapath.
// Expected values are hand-computed constants.
module tb_partial_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] count = 12'd5;
  logic [17:0] base = '0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_idx = '0;
  logic [15:0] cfg_ratio = '0;
  logic [7:0]  cfg_amp = '0;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic [31:0] req_phase;
  logic        resp_valid = 1'b0;
  logic signed [15:0] resp_sample = '0;
  logic [19:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        overrun;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int tick_cyc = 0;
  int sv_cyc = 0;
  int sv_cnt = 0;
  int req_cnt = 0;
  int stable;
  int start;
  logic [31:0] last_phase = '0;
  logic [31:0] phase_q[$];
  logic hs_q = 1'b0;
  logic resp_auto = 1'b1;
  logic resp_force = 1'b0;

  partial_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .sample_cycle_count(count),
    .base_freq_in      (base),
    .cfg_we            (cfg_we),
    .cfg_idx           (cfg_idx),
    .cfg_ratio         (cfg_ratio),
    .cfg_amp           (cfg_amp),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_phase         (req_phase),
    .resp_valid        (resp_valid),
    .resp_sample       (resp_sample),
    .sample_out        (sample_out),
    .sample_valid      (sample_valid),
    .busy              (busy),
    .overrun           (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    hs_q = req_valid && req_ready;
    if (hs_q) begin
      req_cnt++;
      last_phase = req_phase;
      phase_q.push_back(req_phase);
    end
    if (sample_valid) begin
      sv_cnt++;
      sv_cyc = cyc;
    end
  end

  always @(posedge clk) begin
    #1;
    resp_valid = (hs_q && resp_auto) || resp_force;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)",
               tag, got, $signed(got), exp, $signed(exp));
    end
  endtask

  function automatic logic [31:0] sx(input logic [19:0] v);
    return {{12{v[19]}}, v};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] idx, input logic [15:0] r,
                     input logic [7:0] a);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = idx; cfg_ratio = r; cfg_amp = a;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic do_tick();
    @(posedge clk); #1;
    count = 12'd0;
    tick_cyc = cyc;
    @(posedge clk); #1;
    count = 12'd5;
  endtask

  task automatic wait_frame(input string tag, input int budget,
                            input int s0);
    for (int i = 0; i < budget && sv_cnt == s0; i++) @(negedge clk);
    check(tag, 32'(sv_cnt != s0), 32'd1);
  endtask

  task automatic frame(input string tag);
    int s0;
    phase_q.delete();
    req_cnt = 0;
    s0 = sv_cnt;
    do_tick();
    wait_frame(tag, 400, s0);
  endtask

  task automatic wait_req_valid(input string tag);
    for (int i = 0; i < 60 && !req_valid; i++) @(negedge clk);
    check(tag, 32'(req_valid), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_valid", 32'(req_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sample_out", sx(sample_out), 0);
    check("rst_sample_valid", 32'(sample_valid), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_req_phase", req_phase, 0);

    // single partial, unity ratio
    base = 18'd1000;
    resp_sample = 16'sd16384;
    cfg(4'd0, 16'h0100, 8'd255);
    frame("t1_f1_done");
    check("t1_f1_reqs", 32'(req_cnt), 1);
    check("t1_f1_phase", last_phase, 32'd1000);
    check("t1_f1_sample", sx(sample_out), 32'd16320);
    check("t1_latency", 32'(sv_cyc - tick_cyc), 32'd21);
    frame("t1_f2_done");
    check("t1_f2_phase", last_phase, 32'd2000);
    check("t1_f2_sample", sx(sample_out), 32'd16320);

    // all sixteen slots at ratio 1.5
    do_reset();
    resp_sample = 16'sd32767;
    for (int i = 0; i < 16; i++) cfg(4'(i), 16'h0180, 8'd255);
    frame("t2_f1_done");
    check("t2_f1_reqs", 32'(req_cnt), 16);
    check("t2_f1_phase0", phase_q[0], 32'd1500);
    check("t2_f1_phase15", phase_q[15], 32'd1500);
    check("t2_f1_sample", sx(sample_out), 32'd522224);
    check("t2_latency", 32'(sv_cyc - tick_cyc), 32'd66);
    frame("t2_f2_done");
    check("t2_f2_phase7", phase_q[7], 32'd3000);

    // stalled handshake on slot 3
    do_reset();
    resp_sample = -16'sd8000;
    cfg(4'd3, 16'h0100, 8'd128);
    req_ready = 1'b0;
    phase_q.delete();
    req_cnt = 0;
    start = sv_cnt;
    do_tick();
    wait_req_valid("t3_req_up");
    stable = 0;
    repeat (50) begin
      @(negedge clk);
      if (req_valid && req_phase == 32'd1000) stable++;
    end
    check("t3_hold", 32'(stable), 32'd50);
    @(posedge clk); #1 req_ready = 1'b1;
    wait_frame("t3_done", 100, start);
    check("t3_reqs", 32'(req_cnt), 1);
    check("t3_sample", sx(sample_out), -32'sd4000);

    // phase accumulator wrap
    do_reset();
    resp_sample = 16'sd100;
    cfg(4'd0, 16'h8000, 8'd255);
    base = 18'd131072;
    for (int i = 0; i < 255; i++) frame("t4_ramp");
    check("t4_ramp_phase", last_phase, 32'hFF00_0000);
    cfg(4'd0, 16'hFFFF, 8'd255);
    base = 18'd65536;
    frame("t4_pre_done");
    check("t4_pre_phase", last_phase, 32'hFFFF_FF00);
    cfg(4'd0, 16'h0100, 8'd255);
    base = 18'd512;
    frame("t4_wrap_done");
    check("t4_wrap_phase", last_phase, 32'h0000_0100);

    // tick while busy, then reset in WAIT
    do_reset();
    base = 18'd1000;
    resp_sample = 16'sd16384;
    cfg(4'd0, 16'h0100, 8'd255);
    req_ready = 1'b0;
    start = sv_cnt;
    do_tick();
    repeat (5) @(negedge clk);
    do_tick();
    @(negedge clk);
    check("t5_overrun_set", 32'(overrun), 1);
    @(posedge clk); #1 req_ready = 1'b1;
    wait_frame("t5_done", 100, start);
    repeat (40) @(negedge clk);
    check("t5_one_pulse", 32'(sv_cnt - start), 1);
    check("t5_overrun_sticky", 32'(overrun), 1);
    check("t5_sample", sx(sample_out), 32'd16320);
    resp_auto = 1'b0;
    req_cnt = 0;
    do_tick();
    for (int i = 0; i < 60 && req_cnt == 0; i++) @(negedge clk);
    check("t5_issued", 32'(req_cnt), 1);
    repeat (2) @(negedge clk);
    check("t5_in_wait", 32'(busy), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t5_rst_req_valid", 32'(req_valid), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_sample", sx(sample_out), 0);
    check("t5_rst_overrun", 32'(overrun), 0);
    resp_auto = 1'b1;
    start = sv_cnt;
    @(negedge clk) resp_force = 1'b1;
    @(negedge clk) resp_force = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_late_resp_busy", 32'(busy), 0);
    check("t5_late_resp_sv", 32'(sv_cnt - start), 0);

    // empty frame, then cfg write to the in-flight slot
    do_reset();
    frame("t6_empty_done");
    check("t6_empty_reqs", 32'(req_cnt), 0);
    check("t6_empty_latency", 32'(sv_cyc - tick_cyc), 32'd18);
    check("t6_empty_sample", sx(sample_out), 0);
    cfg(4'd0, 16'h0100, 8'd255);
    req_ready = 1'b0;
    start = sv_cnt;
    do_tick();
    wait_req_valid("t6_req_up");
    cfg(4'd0, 16'h0200, 8'd128);
    check("t6_phase_hold", req_phase, 32'd1000);
    @(posedge clk); #1 req_ready = 1'b1;
    wait_frame("t6_f1_done", 100, start);
    check("t6_f1_sample", sx(sample_out), 32'd16320);
    frame("t6_f2_done");
    check("t6_f2_phase", last_phase, 32'd3000);
    check("t6_f2_sample", sx(sample_out), 32'd8192);
    cfg(4'd0, 16'h0000, 8'd128);
    frame("t6_off_done");
    check("t6_off_reqs", 32'(req_cnt), 0);
    cfg(4'd0, 16'h0100, 8'd128);
    frame("t6_on_done");
    check("t6_kept_phase", last_phase, 32'd4000);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
